fetch_bundle_queue: RTL and testbench
=====================================

Name: fetch_bundle_queue

Overview:
Instruction fetch front end between the main memory instruction port and the four execution lanes (ixu1, ixu2, lsu, bru). It owns the fetch PC and prefetches one 128-bit bundle per cycle into a small FIFO. It presents the head bundle, split into per-lane slots, and holds the head while the hazard unit stalls. On a taken branch it flushes the queue and redirects fetch.

Parameters:
DEPTH, 4, bundle queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch address after reset; 16-byte aligned
NOP_INST, 32'h0000_0013, slot value driven when no valid bundle is presented

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fetch_pc  out  32  bundle address to memory instruction port; bits [3:0] always 0
inst_bundle  in  128  bundle returned combinationally for fetch_pc in the same cycle
stall  in  1  hazard stall; head must not be consumed
branch_taken  in  1  redirect request from branch unit
new_pc  in  32  redirect target; bits [3:0] ignored
bundle_valid  out  1  head slots hold a real bundle
bundle_pc  out  32  address of presented bundle (0 when not valid)
ixu1_inst  out  32  head bundle bits [31:0]
ixu2_inst  out  32  head bundle bits [63:32]
lsu_inst  out  32  head bundle bits [95:64]
bru_inst  out  32  head bundle bits [127:96]
squash  out  1  one-cycle pulse, the cycle after redirect accepted
occupancy  out  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (rst=1 at edge): fetch_pc<=RESET_PC; rd/wr pointers<=0; occupancy<=0; squash<=0. Outputs follow from the empty state: bundle_valid=0, all slots=NOP_INST, bundle_pc=0.
- Storage: DEPTH entries of {pc[31:0], bundle[127:0]}, registered. Head outputs are combinational from storage. Empty queue forces NOP_INST and valid=0. No bypass: memory data reaches the outputs no earlier than the cycle after it is fetched.
- push = !full && !branch_taken. On push, write {fetch_pc, inst_bundle} at wr_ptr and fetch_pc <= fetch_pc + 16. Wrap from 32'hFFFF_FFF0 to 0.
- pop = bundle_valid && !stall && !branch_taken.
- Push and pop in the same cycle: occupancy unchanged. Full with pop: push still allowed, because full is evaluated before the edge and the pop frees an entry. Full without pop: fetch_pc held, no write.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from occupancy.
- Redirect (branch_taken=1 in cycle N) has priority over stall, push and pop. At the edge:
  - pointers and occupancy <= 0
  - fetch_pc <= {new_pc[31:4], 4'b0}
  - squash <= 1
- Cycle N+1 after redirect: bundle_valid=0, slots=NOP_INST, squash=1, target fetched and pushed.
- Cycle N+2 after redirect: target bundle presented, squash=0 unless another redirect occurred.
- Back-to-back redirects: each re-flushes; the last target wins.
- Latency: reset deasserted in cycle 0 → first bundle valid in cycle 1. Steady state: one bundle per cycle while stall=0.
- Reset mid-operation overrides redirect and stall.

Decomposition:
- vliw_pkg holds:
  - bundle_t struct {ixu1, ixu2, lsu, bru}, 32 bits each, with lane bit order as in the Ports section
  - BUNDLE_BYTES=16
  - NOP_INST constant
  - fetch_entry_t {pc, bundle}
- One sub-module, sync_fifo (parameterised WIDTH/DEPTH, flush input, occupancy output). It is reusable for LSU store buffering later. The queue's control logic and PC stay in fetch_bundle_queue.

Test Plan:
- Reset then free-run, memory word-address pattern, stall=0 → cycle1 valid, bundle_pc=0x00, then 0x10, 0x20…; ixu1_inst = low word of each bundle; occupancy holds at 1.
- Hold stall=1 from cycle1 with DEPTH=4 → occupancy 1→4, fetch_pc freezes at 0x40, head stays bundle_pc=0x00. Release stall → 0x00,0x10,0x20,0x30,0x40 delivered in consecutive cycles with no gap.
- branch_taken=1, new_pc=0x0000_0124 while occupancy=3 → next cycle occupancy=0, valid=0, slots=0x00000013, squash=1, fetch_pc=0x120. Following cycle bundle_pc=0x120, squash=0.
- Redirect asserted together with stall=1 and queue full → flush still occurs, redirect to target, stall ignored for that cycle.
- RESET_PC=32'hFFFF_FFE0, run 4 cycles → bundle_pc sequence FFFF_FFE0, FFFF_FFF0, 0000_0000; pointers wrap past DEPTH without loss or duplication.
- rst asserted while full and branch_taken=1 → next cycle occupancy=0, squash=0, fetch_pc=RESET_PC.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW fetch path: lane-ordered bundle
// layout and the {pc, bundle} entry held in the fetch queue.
package vliw_pkg;

    localparam int          BUNDLE_BYTES = 16;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    // Packed MSB-first, so ixu1 lands on bits [31:0] and bru on [127:96].
    typedef struct packed {
        logic [31:0] bru;
        logic [31:0] lsu;
        logic [31:0] ixu2;
        logic [31:0] ixu1;
    } bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        bundle_t     bundle;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush and occupancy; a push into a full FIFO
// is accepted when a pop frees the head in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign occupancy = r_count;
    assign rd_data   = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && (!full || w_do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_bundle_queue.sv
// Fetch front end: owns the fetch PC, prefetches one bundle per cycle into a
// queue, presents the head split per lane, and flushes/redirects on a branch.
module fetch_bundle_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = vliw_pkg::NOP_INST
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            fetch_pc,
    input  logic [127:0]           inst_bundle,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [31:0]            new_pc,
    output logic                   bundle_valid,
    output logic [31:0]            bundle_pc,
    output logic [31:0]            ixu1_inst,
    output logic [31:0]            ixu2_inst,
    output logic [31:0]            lsu_inst,
    output logic [31:0]            bru_inst,
    output logic                   squash,
    output logic [$clog2(DEPTH):0] occupancy
);
    import vliw_pkg::*;

    localparam int EW = $bits(fetch_entry_t);

    logic [31:0]   r_fetch_pc;
    logic          r_squash;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_rd_data;
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head;
    logic [3:0]    w_unused_new_pc_lsb;

    assign w_unused_new_pc_lsb = new_pc[3:0];

    // Full is a pre-edge view; a same-cycle pop makes room for the push.
    assign w_pop  = bundle_valid && !stall && !branch_taken;
    assign w_push = (!w_full || w_pop) && !branch_taken;

    assign w_wr_entry.pc     = r_fetch_pc;
    assign w_wr_entry.bundle = bundle_t'(inst_bundle);

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_taken),
        .push      (w_push),
        .pop       (w_pop),
        .wr_data   (w_wr_entry),
        .rd_data   (w_rd_data),
        .full      (w_full),
        .empty     (w_empty),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_squash   <= 1'b0;
        end else begin
            r_squash <= branch_taken;
            if (branch_taken) begin
                r_fetch_pc <= {new_pc[31:4], 4'b0000};
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'(BUNDLE_BYTES);
            end
        end
    end

    assign w_head       = fetch_entry_t'(w_rd_data);
    assign fetch_pc     = r_fetch_pc;
    assign squash       = r_squash;
    assign bundle_valid = !w_empty;
    assign bundle_pc    = bundle_valid ? w_head.pc          : 32'h0;
    assign ixu1_inst    = bundle_valid ? w_head.bundle.ixu1 : NOP_INST;
    assign ixu2_inst    = bundle_valid ? w_head.bundle.ixu2 : NOP_INST;
    assign lsu_inst     = bundle_valid ? w_head.bundle.lsu  : NOP_INST;
    assign bru_inst     = bundle_valid ? w_head.bundle.bru  : NOP_INST;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed bench for fetch_bundle_queue: memory returns each word's own byte
// address, so every lane's expected value follows from the bundle address.
module tb_fetch_bundle_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst, stall, branch_taken;
    logic [31:0]  new_pc;
    logic [31:0]  fetch_pc, bundle_pc, ixu1, ixu2, lsu, bru;
    logic [127:0] inst_bundle;
    logic         bundle_valid, squash;
    logic [2:0]   occupancy;

    logic         rst2;
    logic [31:0]  fetch_pc2, bundle_pc2, ixu1_2, ixu2_2, lsu_2, bru_2;
    logic [127:0] inst_bundle2;
    logic         bundle_valid2, squash2;
    logic [2:0]   occupancy2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign inst_bundle  = {fetch_pc + 32'd12, fetch_pc + 32'd8, fetch_pc + 32'd4, fetch_pc};
    assign inst_bundle2 = {fetch_pc2 + 32'd12, fetch_pc2 + 32'd8, fetch_pc2 + 32'd4, fetch_pc2};

    fetch_bundle_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .inst_bundle(inst_bundle),
        .stall(stall), .branch_taken(branch_taken), .new_pc(new_pc),
        .bundle_valid(bundle_valid), .bundle_pc(bundle_pc),
        .ixu1_inst(ixu1), .ixu2_inst(ixu2), .lsu_inst(lsu), .bru_inst(bru),
        .squash(squash), .occupancy(occupancy)
    );

    fetch_bundle_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFE0)) dut_wrap (
        .clk(clk), .rst(rst2), .fetch_pc(fetch_pc2), .inst_bundle(inst_bundle2),
        .stall(1'b0), .branch_taken(1'b0), .new_pc(32'h0),
        .bundle_valid(bundle_valid2), .bundle_pc(bundle_pc2),
        .ixu1_inst(ixu1_2), .ixu2_inst(ixu2_2), .lsu_inst(lsu_2), .bru_inst(bru_2),
        .squash(squash2), .occupancy(occupancy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and land on cycle 1 (first bundle presented).
    task automatic restart();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; new_pc = 32'h0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (bundle_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bundle_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc got=%h exp=0", fetch_pc); end
        checks++; if (bundle_pc !== 32'h0) begin errors++; $display("FAIL reset_bundle_pc got=%h exp=0", bundle_pc); end
        checks++; if (squash !== 1'b0) begin errors++; $display("FAIL reset_squash got=%0b exp=0", squash); end
        checks++; if ({ixu1, ixu2, lsu, bru} !== {NOP, NOP, NOP, NOP}) begin
            errors++; $display("FAIL reset_slots got=%h %h %h %h exp=%h", ixu1, ixu2, lsu, bru, NOP);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        restart();
        for (int i = 0; i < 6; i++) begin
            exp_pc = 32'(i) * 32'h10;
            checks++; if (bundle_valid !== 1'b1 || bundle_pc !== exp_pc) begin
                errors++; $display("FAIL free_pc[%0d] got v=%0b pc=%h exp pc=%h", i, bundle_valid, bundle_pc, exp_pc);
            end
            checks++; if ({bru, lsu, ixu2, ixu1} !== {exp_pc + 32'd12, exp_pc + 32'd8, exp_pc + 32'd4, exp_pc}) begin
                errors++; $display("FAIL free_slots[%0d] got=%h %h %h %h exp ixu1=%h", i, ixu1, ixu2, lsu, bru, exp_pc);
            end
            checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL free_occ[%0d] got=%0d exp=1", i, occupancy); end
            tick();
        end
    endtask

    task automatic test_stall_fill_drain();
        logic [31:0] exp_fpc;
        logic [2:0]  exp_occ;
        restart();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_occ = (i < 3) ? 3'(i + 1) : 3'd4;
            exp_fpc = (i < 3) ? 32'(i + 1) * 32'h10 : 32'h40;
            checks++; if (occupancy !== exp_occ || fetch_pc !== exp_fpc || bundle_pc !== 32'h0) begin
                errors++; $display("FAIL stall_fill[%0d] got occ=%0d fpc=%h head=%h exp occ=%0d fpc=%h head=0",
                                   i, occupancy, fetch_pc, bundle_pc, exp_occ, exp_fpc);
            end
            tick();
        end
        stall = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'(i) * 32'h10 || occupancy !== 3'd4) begin
                errors++; $display("FAIL stall_drain[%0d] got v=%0b pc=%h occ=%0d exp pc=%h occ=4",
                                   i, bundle_valid, bundle_pc, occupancy, 32'(i) * 32'h10);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        restart();
        stall = 1'b1;
        tick(); tick();
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL redir_pre_occ got=%0d exp=3", occupancy); end
        stall = 1'b0; branch_taken = 1'b1; new_pc = 32'h0000_0124;
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0 || bundle_valid !== 1'b0 || squash !== 1'b1 || fetch_pc !== 32'h120) begin
            errors++; $display("FAIL redir_n1 got occ=%0d v=%0b sq=%0b fpc=%h exp occ=0 v=0 sq=1 fpc=120",
                               occupancy, bundle_valid, squash, fetch_pc);
        end
        checks++; if ({ixu1, ixu2, lsu, bru} !== {NOP, NOP, NOP, NOP} || bundle_pc !== 32'h0) begin
            errors++; $display("FAIL redir_n1_slots got=%h %h %h %h pc=%h exp=%h pc=0", ixu1, ixu2, lsu, bru, bundle_pc, NOP);
        end
        tick();
        checks++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'h120 || squash !== 1'b0 || ixu1 !== 32'h120 || occupancy !== 3'd1) begin
            errors++; $display("FAIL redir_n2 got v=%0b pc=%h sq=%0b ixu1=%h occ=%0d exp v=1 pc=120 sq=0 ixu1=120 occ=1",
                               bundle_valid, bundle_pc, squash, ixu1, occupancy);
        end
    endtask

    task automatic test_redirect_stall_full();
        restart();
        stall = 1'b1;
        tick(); tick(); tick();
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL rsf_pre_occ got=%0d exp=4", occupancy); end
        branch_taken = 1'b1; new_pc = 32'h0000_2008;
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0 || squash !== 1'b1 || fetch_pc !== 32'h2000 || bundle_valid !== 1'b0) begin
            errors++; $display("FAIL rsf_n1 got occ=%0d sq=%0b fpc=%h v=%0b exp occ=0 sq=1 fpc=2000 v=0",
                               occupancy, squash, fetch_pc, bundle_valid);
        end
        tick();
        checks++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'h2000 || occupancy !== 3'd1 || squash !== 1'b0) begin
            errors++; $display("FAIL rsf_n2 got v=%0b pc=%h occ=%0d sq=%0b exp v=1 pc=2000 occ=1 sq=0",
                               bundle_valid, bundle_pc, occupancy, squash);
        end
        stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        restart();
        tick();
        branch_taken = 1'b1; new_pc = 32'h0000_030C;
        tick();
        checks++; if (squash !== 1'b1 || fetch_pc !== 32'h300) begin
            errors++; $display("FAIL b2b_first got sq=%0b fpc=%h exp sq=1 fpc=300", squash, fetch_pc);
        end
        new_pc = 32'h0000_0404;
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (squash !== 1'b1 || fetch_pc !== 32'h400 || occupancy !== 3'd0 || bundle_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_second got sq=%0b fpc=%h occ=%0d v=%0b exp sq=1 fpc=400 occ=0 v=0",
                               squash, fetch_pc, occupancy, bundle_valid);
        end
        tick();
        checks++; if (bundle_pc !== 32'h400 || bundle_valid !== 1'b1 || squash !== 1'b0) begin
            errors++; $display("FAIL b2b_target got pc=%h v=%0b sq=%0b exp pc=400 v=1 sq=0", bundle_pc, bundle_valid, squash);
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        tick();
        exp_pc = 32'hFFFF_FFE0;
        for (int i = 0; i < 7; i++) begin
            checks++; if (bundle_valid2 !== 1'b1 || bundle_pc2 !== exp_pc || ixu1_2 !== exp_pc || bru_2 !== exp_pc + 32'd12) begin
                errors++; $display("FAIL wrap[%0d] got v=%0b pc=%h ixu1=%h bru=%h exp pc=%h",
                                   i, bundle_valid2, bundle_pc2, ixu1_2, bru_2, exp_pc);
            end
            exp_pc = exp_pc + 32'h10;
            tick();
        end
    endtask

    task automatic test_reset_override();
        restart();
        stall = 1'b1;
        tick(); tick(); tick();
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL rov_pre_occ got=%0d exp=4", occupancy); end
        rst = 1'b1; branch_taken = 1'b1; new_pc = 32'h0000_5550;
        tick();
        rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0 || squash !== 1'b0 || fetch_pc !== 32'h0 || bundle_valid !== 1'b0) begin
            errors++; $display("FAIL rov_n1 got occ=%0d sq=%0b fpc=%h v=%0b exp occ=0 sq=0 fpc=0 v=0",
                               occupancy, squash, fetch_pc, bundle_valid);
        end
        tick();
        checks++; if (bundle_pc !== 32'h0 || bundle_valid !== 1'b1) begin
            errors++; $display("FAIL rov_resume got pc=%h v=%0b exp pc=0 v=1", bundle_pc, bundle_valid);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; branch_taken = 1'b0; new_pc = 32'h0;
        test_reset();
        test_free_run();
        test_stall_fill_drain();
        test_redirect();
        test_redirect_stall_full();
        test_back_to_back();
        test_pc_wrap();
        test_reset_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
